seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
- Parametrised, multi-cycle ripple-carry adder/subtractor. Generalises the 4-bit combinational add/sub to WIDTH bits.
- Processes CHUNK bits per clock, LSB chunk first, with the carry held in a register between cycles.
- Uses a start/busy/done handshake and produces carry-out, signed-overflow and zero flags.
- Sits in the lab datapath wherever a narrow, low-area adder is preferred over a wide combinational one.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be ≥ 2.
- CHUNK, 4, bits computed per cycle. Must divide WIDTH exactly; elaboration fails otherwise.
- NCHUNK (localparam) = WIDTH/CHUNK, the number of compute cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only when the block is idle or in the done cycle.
- A  in  WIDTH  operand A, captured on an accepted start.
- B  in  WIDTH  operand B, captured on an accepted start.
- C  in  1  mode, captured on an accepted start: 0 = A+B, 1 = A−B.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse when the result is valid.
- S  out  WIDTH  result register.
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  high when S == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, S, cout, ovf, zero and all internal registers = 0. Deasserting rst_n takes effect at the next clk edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: capture opA=A, opB=B^{WIDTH{C}}, carry=C, mode=C; clear chunk index; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Each edge computes chunk i: sum[i*CHUNK +: CHUNK] = opA chunk + opB chunk + carry, then carry ← chunk carry-out and i ← i+1.
  - At the edge that completes chunk NCHUNK−1, go to DONE.
  - start is ignored in RUN; there is no queueing.
- DONE (one cycle):
  - done=1.
  - S, cout, ovf and zero are loaded at the edge entering DONE.
  - ovf = (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]), using the inverted B.
  - Next edge: if start=1, accept new operands exactly as in IDLE and go to RUN (back-to-back); otherwise go to IDLE.
- Timing:
  - busy is high in RUN only.
  - start accepted at edge k → busy high from k+1 through k+NCHUNK → done high in the cycle after edge k+NCHUNK.
  - Latency from accepted start to done is NCHUNK+1 edges.
  - Throughput is one operation per NCHUNK+1 cycles.
- Output stability: S and the flags hold the last completed result through IDLE and RUN, and change only on entry to DONE. Partial sums are never visible on S.
- Operand inputs: A, B and C may change freely after capture without affecting the operation in flight.
- CHUNK == WIDTH: NCHUNK=1. The RUN phase is one cycle and latency is 2 edges.
- Reset mid-RUN: the operation is abandoned. done never pulses and outputs read 0.
- Arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Package addsub_pkg holds the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a chunk-count helper function.
- Sub-module addsub_chunk: combinational CHUNK-bit ripple of full adders.
  - Inputs a[CHUNK], b[CHUNK], cin.
  - Outputs s[CHUNK], cout.
  - Also outputs the MSB carry-in, so the top level can compute ovf as c_in_msb ^ cout on the final chunk, which is equivalent to the formula above.
- The top level holds the FSM, the operand/result shift registers and the flag logic.

Test Plan:
- WIDTH=4, CHUNK=1: A=6, B=5, C=1, pulse start → done 5 edges later; S=4'b0001, cout=1, ovf=0, zero=0.
- WIDTH=16, CHUNK=4: A=16'h7FFF, B=16'h0001, C=0 → S=16'h8000, cout=0, ovf=1, zero=0. busy high for exactly 4 cycles, then done high for exactly 1.
- A=16'h1234, B=16'h1234, C=1 → S=0, cout=1, zero=1, ovf=0. A=0, B=1, C=1 → S=16'hFFFF, cout=0, ovf=0.
- Hold start=1 continuously with new operands each DONE cycle → back-to-back results every 5 cycles. Start pulses during RUN are ignored. S is unchanged between done pulses.
- Assert rst_n=0 asynchronously mid-RUN (between edges) → busy, S and the flags go to 0 immediately and no done pulse follows. The next start completes normally: A=16'hFFFF, B=1, C=0 → S=0, cout=1, zero=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential adder/subtractor: FSM state
// encoding and elaboration-time sizing helpers.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of compute cycles needed to cover the full operand width.
   function automatic int chunk_count(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Width of the chunk index; at least one bit even when one chunk suffices.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice. Exposes the carry into
// the top bit so the caller can derive signed overflow on the final chunk.
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_in_msb
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   // One full adder per bit, carry rippling upwards.
   for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
   end

   assign cout     = c[CHUNK];
   assign c_in_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that resolves CHUNK bits per clock,
// LSB chunk first, carrying between cycles in a register. Results and flags
// are published only on entry to the one-cycle DONE state.
module seq_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
   localparam int IDXW   = idx_width(NCHUNK);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   // Refuse to elaborate with a width that cannot be split evenly.
   if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum_acc;
   logic             carry;
   logic [IDXW-1:0]  idx;

   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic [CHUNK-1:0] chunk_s;
   logic             chunk_cout;
   logic             chunk_c_msb;
   logic [WIDTH-1:0] sum_full;

   // Select the current chunk of each operand and merge its sum into the
   // partial result so the final edge can publish the complete word.
   always_comb begin
      chunk_a  = op_a[idx*CHUNK +: CHUNK];
      chunk_b  = op_b[idx*CHUNK +: CHUNK];
      sum_full = sum_acc;
      sum_full[idx*CHUNK +: CHUNK] = chunk_s;
   end

   addsub_chunk #(
      .CHUNK(CHUNK)
   ) u_chunk (
      .a        (chunk_a),
      .b        (chunk_b),
      .cin      (carry),
      .s        (chunk_s),
      .cout     (chunk_cout),
      .c_in_msb (chunk_c_msb)
   );

   // Control FSM plus operand capture, chunk stepping and result publication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_a    <= '0;
         op_b    <= '0;
         sum_acc <= '0;
         carry   <= 1'b0;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         S       <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  // Subtraction is A + ~B + 1: invert B and seed the carry.
                  op_a  <= A;
                  op_b  <= B ^ {WIDTH{C}};
                  carry <= C;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               sum_acc <= sum_full;
               carry   <= chunk_cout;
               idx     <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  // Overflow is the carry into the MSB differing from the carry out.
                  S     <= sum_full;
                  cout  <= chunk_cout;
                  ovf   <= chunk_c_msb ^ chunk_cout;
                  zero  <= (sum_full == '0);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub: a 16-bit/4-bit-chunk instance and a
// 4-bit/1-bit-chunk instance, checked against hand-computed results.
module tb_seq_addsub;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic        c16 = 1'b0;
   logic        busy16, done16, cout16, ovf16, zero16;
   logic [15:0] s16;

   logic        start4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        c4 = 1'b0;
   logic        busy4, done4, cout4, ovf4, zero4;
   logic [3:0]  s4;

   int errors = 0;
   int checks = 0;
   logic [15:0] last_s = '0;

   always #5 clk = ~clk;

   seq_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16), .C(c16),
      .busy(busy16), .done(done16), .S(s16), .cout(cout16), .ovf(ovf16), .zero(zero16)
   );

   seq_addsub #(.WIDTH(4), .CHUNK(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .C(c4),
      .busy(busy4), .done(done4), .S(s4), .cout(cout4), .ovf(ovf4), .zero(zero4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One 16-bit operation: pulse start, count busy cycles, check the result.
   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez);
      int nbusy;
      int guard;
      @(negedge clk);
      a16 = a; b16 = b; c16 = c; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      a16 = $urandom; b16 = $urandom; c16 = ~c;
      nbusy = 0;
      guard = 0;
      while (!done16 && guard < 20) begin
         if (busy16) nbusy++;
         check({tag, "_hold"}, s16, last_s);
         @(negedge clk);
         guard++;
      end
      check({tag, "_busy_cycles"}, nbusy, 4);
      check({tag, "_done"}, done16, 1'b1);
      check({tag, "_S"}, s16, es);
      check({tag, "_cout"}, cout16, ec);
      check({tag, "_ovf"}, ovf16, eo);
      check({tag, "_zero"}, zero16, ez);
      $display("op %s A=%h B=%h C=%0d -> S=%h cout=%0d ovf=%0d zero=%0d", tag, a, b, c,
               s16, cout16, ovf16, zero16);
      last_s = es;
      @(negedge clk);
      check({tag, "_done_pulse"}, done16, 1'b0);
      check({tag, "_S_stable"}, s16, es);
   endtask

   initial begin : stim
      logic [15:0] bb_a [3];
      logic [15:0] bb_b [3];
      logic        bb_c [3];
      logic [15:0] bb_s [3];
      logic        bb_co[3];
      logic        bb_ov[3];
      logic        bb_z [3];
      int cycles;
      int dones;

      bb_a = '{16'h1000, 16'h0005, 16'h4000};
      bb_b = '{16'h0234, 16'h0005, 16'h4000};
      bb_c = '{1'b0, 1'b1, 1'b0};
      bb_s = '{16'h1234, 16'h0000, 16'h8000};
      bb_co = '{1'b0, 1'b1, 1'b0};
      bb_ov = '{1'b0, 1'b0, 1'b1};
      bb_z  = '{1'b0, 1'b1, 1'b0};

      // Reset state
      #12;
      check("rst_busy", busy16, 1'b0);
      check("rst_done", done16, 1'b0);
      check("rst_S", s16, 16'h0);
      check("rst_flags", {cout16, ovf16, zero16}, 3'b000);
      check("rst_S4", s4, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // 4-bit, 1-bit chunks: 6 - 5
      @(negedge clk);
      a4 = 4'd6; b4 = 4'd5; c4 = 1'b1; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; a4 = 4'hF; b4 = 4'hF; c4 = 1'b0;
      cycles = 1;
      while (!done4 && cycles < 20) begin
         check("w4_busy", busy4, 1'b1);
         @(negedge clk);
         cycles++;
      end
      check("w4_latency", cycles, 5);
      check("w4_S", s4, 4'b0001);
      check("w4_flags", {cout4, ovf4, zero4}, 3'b100);
      $display("op w4 A=6 B=5 C=1 -> S=%h cout=%0d ovf=%0d zero=%0d", s4, cout4, ovf4, zero4);

      // 16-bit directed operations
      run16("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      run16("sub_eq",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      run16("sub_brw", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      run16("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

      // Back-to-back with start held high; new operands presented during RUN
      @(negedge clk);
      a16 = bb_a[0]; b16 = bb_b[0]; c16 = bb_c[0]; start16 = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("bb_busy_start", busy16, 1'b1);
         if (j < 2) begin
            a16 = bb_a[j+1]; b16 = bb_b[j+1]; c16 = bb_c[j+1];
         end else begin
            start16 = 1'b0; a16 = $urandom; b16 = $urandom;
         end
         cycles = 1;
         while (!done16 && cycles < 20) begin
            check("bb_hold", s16, last_s);
            @(negedge clk);
            cycles++;
         end
         check("bb_period", cycles, 5);
         check("bb_S", s16, bb_s[j]);
         check("bb_flags", {cout16, ovf16, zero16}, {bb_co[j], bb_ov[j], bb_z[j]});
         $display("op bb%0d A=%h B=%h C=%0d -> S=%h cout=%0d ovf=%0d zero=%0d", j,
                  bb_a[j], bb_b[j], bb_c[j], s16, cout16, ovf16, zero16);
         last_s = bb_s[j];
      end
      @(negedge clk);
      check("bb_end_idle", {busy16, done16}, 2'b00);

      // Asynchronous reset mid-RUN
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h1111; c16 = 1'b0; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy16, 1'b0);
      check("arst_S", s16, 16'h0);
      check("arst_flags", {cout16, ovf16, zero16}, 3'b000);
      $display("op arst -> busy=%0d S=%h", busy16, s16);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_s = 16'h0;
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done16) dones++;
      end
      check("arst_no_done", dones, 0);
      run16("post_rst", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
